// File: rtl/video_pattern_pkg.sv
// Shared types and colour constants for the video pattern engine.
// Mode 3 (SCROLL) is only live when VIDEO_PATTERN_SCROLL_EN is defined.
package video_pattern_pkg;

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    CHECKER  = 2'd1,
    GRADIENT = 2'd2,
    SCROLL   = 2'd3
  } mode_e;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Free-running H/V raster counters with combinational active-video and
// active-low sync decode of the current count.
module video_timing_counter #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [9:0] o_hpos,
  output logic [9:0] o_vpos,
  output logic       o_visible,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_line_end,
  output logic       o_frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_L  = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_S = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_E = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_S = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_E = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] r_hpos;
  logic [9:0] r_vpos;
  logic       w_h_wrap;
  logic       w_v_wrap;

  assign w_h_wrap = (r_hpos == H_LAST);
  assign w_v_wrap = (r_vpos == V_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hpos <= '0;
      r_vpos <= '0;
    end else if (w_h_wrap) begin
      r_hpos <= '0;
      r_vpos <= w_v_wrap ? '0 : r_vpos + 10'd1;
    end else begin
      r_hpos <= r_hpos + 10'd1;
    end
  end

  assign o_hpos        = r_hpos;
  assign o_vpos        = r_vpos;
  assign o_visible     = (r_hpos < H_VIS_L) && (r_vpos < V_VIS_L);
  assign o_hsync       = !((r_hpos >= H_SYNC_S) && (r_hpos < H_SYNC_E));
  assign o_vsync       = !((r_vpos >= V_SYNC_S) && (r_vpos < V_SYNC_E));
  assign o_line_end    = w_h_wrap;
  assign o_frame_start = (r_hpos == 10'd0) && (r_vpos == 10'd0);

endmodule

// File: rtl/video_pattern_engine.sv
// Test-pattern generator: raster timing, four selectable patterns and one
// registered output stage. Define VIDEO_PATTERN_SCROLL_EN to build mode 3.
module video_pattern_engine
  import video_pattern_pkg::*;
#(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int BAR_WIDTH   = 80,
  parameter int CHECK_SHIFT = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_mode,
  output logic [9:0] o_sdl_hpos,
  output logic [9:0] o_sdl_vpos,
  output logic       o_sdl_visible,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic [7:0] o_sdl_r,
  output logic [7:0] o_sdl_g,
  output logic [7:0] o_sdl_b
);

  localparam logic [9:0] BAR_LAST = 10'(BAR_WIDTH - 1);

  logic [9:0]  w_hpos;
  logic [9:0]  w_vpos;
  logic        w_visible;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_line_end;
  logic        w_frame_start;

  mode_e       r_mode;
  mode_e       w_mode;
  logic [2:0]  r_bar_idx;
  logic [9:0]  r_bar_sub;
  logic [23:0] w_rgb;

  logic [9:0]  r_out_hpos;
  logic [9:0]  r_out_vpos;
  logic        r_out_visible;
  logic        r_out_hsync;
  logic        r_out_vsync;
  logic [23:0] r_out_rgb;

  video_timing_counter #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK)
  ) u_timing (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_hpos        (w_hpos),
    .o_vpos        (w_vpos),
    .o_visible     (w_visible),
    .o_hsync       (w_hsync),
    .o_vsync       (w_vsync),
    .o_line_end    (w_line_end),
    .o_frame_start (w_frame_start)
  );

  // The first pixel of a frame already uses the freshly sampled mode.
  assign w_mode = w_frame_start ? mode_e'(i_mode) : r_mode;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode <= BARS;
    end else if (w_frame_start) begin
      r_mode <= mode_e'(i_mode);
    end
  end

  // Bar index and sub-counter describe the current hpos; they return to
  // zero together with the horizontal counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bar_idx <= '0;
      r_bar_sub <= '0;
    end else if (w_line_end) begin
      r_bar_idx <= '0;
      r_bar_sub <= '0;
    end else if (r_bar_sub == BAR_LAST) begin
      r_bar_sub <= '0;
      if (r_bar_idx != 3'd7) begin
        r_bar_idx <= r_bar_idx + 3'd1;
      end
    end else begin
      r_bar_sub <= r_bar_sub + 10'd1;
    end
  end

`ifdef VIDEO_PATTERN_SCROLL_EN
  localparam int         V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

  logic [7:0] r_frame;
  logic [9:0] w_scroll_h;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame <= '0;
    end else if (w_line_end && (w_vpos == V_LAST)) begin
      r_frame <= r_frame + 8'd1;
    end
  end

  assign w_scroll_h = w_hpos + {2'b00, r_frame};
`endif

  always_comb begin
    w_rgb = C_BLACK;
    case (w_mode)
      BARS:     w_rgb = bar_colour(r_bar_idx);
      CHECKER:  w_rgb = (w_hpos[CHECK_SHIFT] ^ w_vpos[CHECK_SHIFT]) ? C_WHITE : C_BLACK;
      GRADIENT: w_rgb = {w_hpos[7:0], w_vpos[7:0], 8'h80};
`ifdef VIDEO_PATTERN_SCROLL_EN
      SCROLL:   w_rgb = (w_scroll_h[CHECK_SHIFT] ^ w_vpos[CHECK_SHIFT]) ? C_WHITE : C_BLACK;
`else
      SCROLL:   w_rgb = C_BLACK;
`endif
      default:  w_rgb = C_BLACK;
    endcase
    if (!w_visible) begin
      w_rgb = C_BLACK;
    end
  end

  // Single output stage: colour and all raster qualifiers leave together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_hpos    <= '0;
      r_out_vpos    <= '0;
      r_out_visible <= 1'b0;
      r_out_hsync   <= 1'b1;
      r_out_vsync   <= 1'b1;
      r_out_rgb     <= '0;
    end else begin
      r_out_hpos    <= w_hpos;
      r_out_vpos    <= w_vpos;
      r_out_visible <= w_visible;
      r_out_hsync   <= w_hsync;
      r_out_vsync   <= w_vsync;
      r_out_rgb     <= w_rgb;
    end
  end

  assign o_sdl_hpos    = r_out_hpos;
  assign o_sdl_vpos    = r_out_vpos;
  assign o_sdl_visible = r_out_visible;
  assign o_hsync       = r_out_hsync;
  assign o_vsync       = r_out_vsync;
  assign o_sdl_r       = r_out_rgb[23:16];
  assign o_sdl_g       = r_out_rgb[15:8];
  assign o_sdl_b       = r_out_rgb[7:0];

endmodule
